// File: rtl/rom_bridge.sv
// rom_bridge: connects a CPU bus to a 2 KB synchronous ROM window at ROM_BASE.
// ROM reads stall the CPU for 1 cycle (PIPE=0, bypass ROM) or 2 cycles (PIPE=1,
// ROM with output register). All other accesses complete with zero wait states
// and return ext_di.
// Ports:
//   clk, reset      - system clock, synchronous active-low reset
//   cpu_ab/valid/we - CPU address, access valid, write strobe
//   cpu_rdy, cpu_di - CPU ready (0 = stall) and read data (combinational)
//   ext_di          - read data from non-ROM devices
//   rom_ad/ce/oce   - ROM address, clock enable, output-register enable
//   rom_dout        - ROM read data
//   wr_err          - sticky flag, a write hit the ROM window
//   rd_cnt          - saturating count of completed ROM reads
module rom_bridge #(
  parameter logic [15:0] ROM_BASE = 16'hF800,
  parameter int unsigned PIPE     = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_ab,
  input  logic        cpu_valid,
  input  logic        cpu_we,
  output logic        cpu_rdy,
  output logic [7:0]  cpu_di,
  input  logic [7:0]  ext_di,
  output logic [10:0] rom_ad,
  output logic        rom_ce,
  output logic        rom_oce,
  input  logic [7:0]  rom_dout,
  output logic        wr_err,
  output logic [15:0] rd_cnt
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_wr_err;
  logic [CNT_W-1:0]   r_rd_cnt;
  logic               w_hit;
  logic               w_rd_hit;
  logic               w_wr_hit;

  // Window decode on the upper 5 address bits
  assign w_hit    = cpu_valid && (cpu_ab[15:11] == ROM_BASE[15:11]);
  assign w_rd_hit = w_hit && !cpu_we;
  assign w_wr_hit = w_hit && cpu_we;

  assign rom_ad = cpu_ab[10:0];
  assign wr_err = r_wr_err;
  assign rd_cnt = r_rd_cnt;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; WAIT/RESP ignore the bus so a misbehaving CPU cannot derail a read
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_rd_hit) begin
          w_next = (PIPE != 0) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT:  w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output logic; everything is held inactive while reset is low
  always_comb begin
    cpu_rdy = 1'b0;
    cpu_di  = 8'h00;
    rom_ce  = 1'b0;
    rom_oce = 1'b0;
    if (reset) begin
      case (r_state)
        S_IDLE: begin
          if (w_rd_hit) begin
            rom_ce = 1'b1;
          end else begin
            cpu_rdy = 1'b1;
            cpu_di  = ext_di;
          end
        end
        S_WAIT: begin
          rom_oce = (PIPE != 0);
        end
        S_RESP: begin
          cpu_rdy = 1'b1;
          cpu_di  = rom_dout;
        end
        default: begin
          cpu_rdy = 1'b0;
        end
      endcase
    end
  end

  // Status registers: sticky write error and saturating read counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_err <= 1'b0;
      r_rd_cnt <= '0;
    end else begin
      if (r_state == S_IDLE && w_wr_hit) begin
        r_wr_err <= 1'b1;
      end
      if (r_state == S_RESP && r_rd_cnt != {CNT_W{1'b1}}) begin
        r_rd_cnt <= r_rd_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_rom_bridge.sv
// Self-checking bench for rom_bridge: one PIPE=0 and one PIPE=1 instance share
// address/write/ext data and reset; each has its own valid and its own ROM model.
module tb_rom_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] ab;
  logic        we;
  logic [7:0]  ext;
  logic        valid0, valid1;
  logic        rdy0, rdy1;
  logic [7:0]  di0, di1;
  logic [10:0] ad0, ad1;
  logic        ce0, ce1, oce0, oce1;
  logic [7:0]  dout0, dout1;
  logic        err0, err1;
  logic [15:0] cnt0, cnt1;

  logic [7:0]  rom_mem [2048];
  logic [10:0] areg1;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int exp_cnt [2];
  int exp_err [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rom_bridge #(.ROM_BASE(16'hF800), .PIPE(0)) u_dut0 (
    .clk(clk), .reset(reset), .cpu_ab(ab), .cpu_valid(valid0), .cpu_we(we),
    .cpu_rdy(rdy0), .cpu_di(di0), .ext_di(ext), .rom_ad(ad0), .rom_ce(ce0),
    .rom_oce(oce0), .rom_dout(dout0), .wr_err(err0), .rd_cnt(cnt0)
  );

  rom_bridge #(.ROM_BASE(16'hF800), .PIPE(1)) u_dut1 (
    .clk(clk), .reset(reset), .cpu_ab(ab), .cpu_valid(valid1), .cpu_we(we),
    .cpu_rdy(rdy1), .cpu_di(di1), .ext_di(ext), .rom_ad(ad1), .rom_ce(ce1),
    .rom_oce(oce1), .rom_dout(dout1), .wr_err(err1), .rd_cnt(cnt1)
  );

  // Bypass ROM: data one cycle after ce
  always @(posedge clk) if (ce0) dout0 <= rom_mem[ad0];

  // Pipelined ROM: address captured on ce, data registered on oce
  always @(posedge clk) begin
    if (ce1)  areg1 <= ad1;
    if (oce1) dout1 <= rom_mem[areg1];
  end

  function automatic logic g_rdy(input int s);  return s != 0 ? rdy1 : rdy0; endfunction
  function automatic logic [7:0] g_di(input int s); return s != 0 ? di1 : di0; endfunction
  function automatic logic [10:0] g_ad(input int s); return s != 0 ? ad1 : ad0; endfunction
  function automatic logic g_ce(input int s);   return s != 0 ? ce1 : ce0; endfunction
  function automatic logic g_oce(input int s);  return s != 0 ? oce1 : oce0; endfunction
  function automatic logic g_err(input int s);  return s != 0 ? err1 : err0; endfunction
  function automatic logic [15:0] g_cnt(input int s); return s != 0 ? cnt1 : cnt0; endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0; ab = 16'hF800; we = 1'b0; valid0 = 1'b1; valid1 = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("rst_rdy0", 32'(rdy0), 0);   check("rst_rdy1", 32'(rdy1), 0);
      check("rst_ce0", 32'(ce0), 0);     check("rst_ce1", 32'(ce1), 0);
      check("rst_oce1", 32'(oce1), 0);   check("rst_di1", 32'(di1), 0);
      @(posedge clk); #1;
    end
    valid0 = 1'b0; valid1 = 1'b0; reset = 1'b1;
    exp_cnt[0] = 0; exp_cnt[1] = 0; exp_err[0] = 0; exp_err[1] = 0;
    @(negedge clk);
    check("post_rst_rdy0", 32'(rdy0), 1); check("post_rst_rdy1", 32'(rdy1), 1);
    check("post_rst_ce1", 32'(ce1), 0);   check("post_rst_cnt1", 32'(cnt1), 0);
    check("post_rst_err1", 32'(err1), 0); check("post_rst_cnt0", 32'(cnt0), 0);
    @(posedge clk); #1;
  endtask

  // One CPU access on instance s, held until ready; compared against window rules
  task automatic access(input int s, input logic [15:0] a, input logic w, input logic [7:0] e);
    logic hit, rd;
    int   stalls, exp_stall;
    hit = (a[15:11] == 5'h1F);
    rd  = hit && !w;
    exp_stall = rd ? (s != 0 ? 2 : 1) : 0;
    ab = a; we = w; ext = e;
    valid0 = (s == 0); valid1 = (s != 0);
    @(negedge clk);
    check("rom_ad", 32'(g_ad(s)), 32'(a[10:0]));
    check("rom_ce", 32'(g_ce(s)), 32'(rd));
    stalls = 0;
    while (!g_rdy(s) && stalls < 8) begin
      check("rom_oce", 32'(g_oce(s)), 32'(s != 0 && stalls == 1));
      @(negedge clk);
      stalls++;
    end
    check("stalls", 32'(stalls), 32'(exp_stall));
    if (!w) check("cpu_di", 32'(g_di(s)), rd ? 32'(rom_mem[a[10:0]]) : 32'(e));
    @(posedge clk); #1;
    if (rd && exp_cnt[s] < 16'hFFFF) exp_cnt[s]++;
    if (hit && w) exp_err[s] = 1;
    check("rd_cnt", 32'(g_cnt(s)), 32'(exp_cnt[s]));
    check("wr_err", 32'(g_err(s)), 32'(exp_err[s]));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int t0;
    logic [15:0] a;
    for (int i = 0; i < 2048; i++) rom_mem[i] = 8'($urandom);
    rom_mem[0] = 8'hA9;
    reset = 1'b0; ab = 16'h0; we = 1'b0; ext = 8'h0; valid0 = 1'b0; valid1 = 1'b0;

    do_reset(3);

    // Pipelined read of offset 0
    access(1, 16'hF800, 1'b0, 8'h00);

    // Back-to-back bypass reads: 2 cycles each
    t0 = cyc;
    for (int i = 1; i <= 5; i++) access(0, 16'hF800 + 16'(i), 1'b0, 8'h11);
    check("b2b_cycles", 32'(cyc - t0), 10);
    check("b2b_cnt", 32'(cnt0), 5);

    // Non-ROM read and ROM-window write on both instances
    access(0, 16'h0200, 1'b0, 8'h5C);
    access(1, 16'h0200, 1'b0, 8'h5C);
    access(1, 16'hFFFC, 1'b1, 8'h00);
    access(0, 16'hFFFC, 1'b1, 8'h00);
    access(1, 16'hF7FF, 1'b0, 8'h3E);

    // Random traffic
    for (int i = 0; i < 60; i++) begin
      a = ($urandom_range(0, 1) != 0) ? {5'h1F, 11'($urandom)} : 16'($urandom);
      access(int'($urandom_range(0, 1)), a, ($urandom_range(0, 3) == 0), 8'($urandom));
    end

    // Reset while the pipelined read sits in WAIT
    do_reset(1);
    ab = 16'hF800; we = 1'b0; valid1 = 1'b1;
    @(negedge clk);
    check("abort_ce", 32'(ce1), 1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_rdy", 32'(rdy1), 0);
    check("abort_oce", 32'(oce1), 0);
    @(posedge clk); #1;
    check("abort_cnt", 32'(cnt1), 0);
    valid1 = 1'b0; reset = 1'b1;
    @(negedge clk);
    check("abort_idle_rdy", 32'(rdy1), 1);
    @(posedge clk); #1;
    access(1, 16'hF800, 1'b0, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
